// File: rtl/alu_control_mdu.sv
// ALU control decode plus a bit-serial unsigned multiply/divide unit with HI/LO.
// multu/divu take WIDTH iteration cycles, and HI/LO load on entry to DONE.
module alu_control_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       funct,
  input  logic [2:0]       ALUOp,
  input  logic             valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALUCtrl,
  output logic [1:0]       res_sel,
  output logic             stall,
  output logic             mdu_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 start, busy;
  logic [WIDTH:0]       mul_upper;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_take;

  always_comb begin
    ALUCtrl = 4'b1111;
    res_sel = 2'b00;
    case (ALUOp)
      3'b000: ALUCtrl = 4'b0000;
      3'b001: ALUCtrl = 4'b0001;
      3'b010: ALUCtrl = 4'b0010;
      3'b011: ALUCtrl = 4'b0110;
      3'b100: begin
        case (funct)
          6'b100000: ALUCtrl = 4'b0010;
          6'b100010: ALUCtrl = 4'b0110;
          6'b100100: ALUCtrl = 4'b0000;
          6'b100101: ALUCtrl = 4'b0001;
          6'b101010: ALUCtrl = 4'b0111;
          6'b100111: ALUCtrl = 4'b1100;
          default:   ALUCtrl = 4'b1111;
        endcase
        if (funct == F_MFHI) res_sel = 2'b01;
        else if (funct == F_MFLO) res_sel = 2'b10;
      end
      default: ALUCtrl = 4'b1111;
    endcase
  end

  assign start    = valid && (ALUOp == 3'b100) && (state_q == S_IDLE) &&
                    ((funct == F_MULTU) || (funct == F_DIVU));
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall    = !reset && (start || busy);
  assign mdu_done = !reset && (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Multiply: upper half accumulates the multiplicand, whole product shifts right.
  assign mul_upper = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
  // Divide: remainder in the upper half, dividend/quotient shifts left in the lower half.
  assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_take  = div_shift >= {1'b0, a_q};
  assign div_diff  = div_shift[WIDTH-1:0] - a_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (funct == F_MULTU) begin
            a_d     = op_a;
            p_d     = {{WIDTH{1'b0}}, op_b};
            state_d = S_MUL;
          end else begin
            a_d     = op_b;
            p_d     = {{WIDTH{1'b0}}, op_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL)
          p_d = {mul_upper, p_q[WIDTH-1:1]};
        else
          p_d = {(div_take ? div_diff : div_shift[WIDTH-1:0]), p_q[WIDTH-2:0], div_take};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          hi_d    = p_d[2*WIDTH-1:WIDTH];
          lo_d    = p_d[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode sweep, multu/divu latency and results via a
// scoreboard, mflo interlock, reset abort and ignored restarts.
module tb_alu_control_mdu;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   funct;
  logic [2:0]   ALUOp;
  logic         valid;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   ALUCtrl;
  logic [1:0]   res_sel;
  logic         stall, mdu_done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int push_cnt = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] last_hi = '0, last_lo = '0;

  alu_control_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .funct(funct), .ALUOp(ALUOp), .valid(valid),
    .op_a(op_a), .op_b(op_b), .ALUCtrl(ALUCtrl), .res_sel(res_sel),
    .stall(stall), .mdu_done(mdu_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    valid = 1'b0; ALUOp = 3'b000; funct = 6'b000000;
  endtask

  function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    if (f == F_MULTU) r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (b == '0) r = {a, {W{1'b1}}};
    else r = {a % b, a / b};
    return r;
  endfunction

  // Scoreboard: every mdu_done pulse pops one expected {hi,lo}.
  always @(negedge clk) begin
    if (mdu_done === 1'b1) begin
      logic [2*W-1:0] e;
      done_cnt++;
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(e[2*W-1:W]));
        chk("lo", 64'(lo), 64'(e[W-1:0]));
        $display("done #%0d hi=%h lo=%h", done_cnt, hi, lo);
        last_hi = e[2*W-1:W];
        last_lo = e[W-1:0];
      end
    end
  end

  // mode 0: plain; 1: mflo issued from offset 5; 2: a second multu held valid while busy
  task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    @(posedge clk); #1;
    valid = 1'b1; ALUOp = 3'b100; funct = f; op_a = a; op_b = b;
    @(negedge clk);
    chk("start_stall", 64'(stall), 64'd1);
    exp_q.push_back(model(f, a, b));
    push_cnt++;
    $display("start %s a=%h b=%h mode=%0d", (f == F_MULTU) ? "multu" : "divu", a, b, mode);
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      drive_idle();
      if (mode == 1 && k >= 5) begin
        valid = 1'b1; ALUOp = 3'b100; funct = F_MFLO;
      end else if (mode == 2 && k <= W) begin
        valid = 1'b1; ALUOp = 3'b100; funct = F_MULTU; op_a = a + 1; op_b = b + 3;
      end
      @(negedge clk);
      if (k <= W) begin
        chk("busy_stall", 64'(stall), 64'd1);
        chk("busy_done", 64'(mdu_done), 64'd0);
        chk("busy_hi_hold", 64'(hi), 64'(last_hi));
        chk("busy_lo_hold", 64'(lo), 64'(last_lo));
      end else begin
        chk("done_pulse", 64'(mdu_done), 64'd1);
        chk("done_stall", 64'(stall), 64'd0);
      end
      if (mode == 1 && k >= 5) chk("mflo_res_sel", 64'(res_sel), 64'd2);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("after_done", 64'(mdu_done), 64'd0);
  endtask

  typedef struct { logic [2:0] aop; logic [5:0] fn; logic [3:0] ctrl; logic [1:0] sel; } dec_t;
  dec_t dec_tab[$] = '{
    '{3'b010, 6'b000000, 4'b0010, 2'b00}, '{3'b011, 6'b101010, 4'b0110, 2'b00},
    '{3'b000, 6'b100111, 4'b0000, 2'b00}, '{3'b001, 6'b000000, 4'b0001, 2'b00},
    '{3'b100, 6'b100000, 4'b0010, 2'b00}, '{3'b100, 6'b100010, 4'b0110, 2'b00},
    '{3'b100, 6'b100100, 4'b0000, 2'b00}, '{3'b100, 6'b100101, 4'b0001, 2'b00},
    '{3'b100, 6'b101010, 4'b0111, 2'b00}, '{3'b100, 6'b100111, 4'b1100, 2'b00},
    '{3'b100, 6'b000000, 4'b1111, 2'b00}, '{3'b100, 6'b010000, 4'b1111, 2'b01},
    '{3'b100, 6'b010010, 4'b1111, 2'b10}, '{3'b100, 6'b011001, 4'b1111, 2'b00},
    '{3'b010, 6'b010000, 4'b0010, 2'b00}, '{3'b101, 6'b100000, 4'b1111, 2'b00},
    '{3'b111, 6'b010010, 4'b1111, 2'b00}
  };

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op_a = '0; op_b = '0;
    valid = 1'b1; ALUOp = 3'b100; funct = F_MULTU;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(mdu_done), 64'd0);
    ALUOp = 3'b010; valid = 1'b0; #1;
    chk("rst_aluctrl", 64'(ALUCtrl), 64'h2);
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b0;

    foreach (dec_tab[i]) begin
      ALUOp = dec_tab[i].aop; funct = dec_tab[i].fn; valid = 1'b0;
      #1;
      chk($sformatf("dec_ctrl_%0d", i), 64'(ALUCtrl), 64'(dec_tab[i].ctrl));
      chk($sformatf("dec_sel_%0d", i), 64'(res_sel), 64'(dec_tab[i].sel));
      $display("decode aluop=%b funct=%b ctrl=%b sel=%b", ALUOp, funct, ALUCtrl, res_sel);
    end
    drive_idle();

    run_mdu(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_mdu(F_DIVU, 32'd100, 32'd7, 0);
    run_mdu(F_DIVU, 32'd5, 32'd0, 0);
    run_mdu(F_MULTU, 32'd12345, 32'd678, 1);
    run_mdu(F_MULTU, 32'd7, 32'd9, 2);

    // Reset ten cycles into a divide must discard it.
    @(posedge clk); #1;
    valid = 1'b1; ALUOp = 3'b100; funct = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    drive_idle();
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_stall", 64'(stall), 64'd0);
    chk("abort_done", 64'(mdu_done), 64'd0);
    $display("reset during divu: hi=%h lo=%h", hi, lo);
    last_hi = '0; last_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 64'(stall), 64'd0);
    run_mdu(F_MULTU, 32'd3, 32'd4, 0);

    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (r == 3) ? 32'($urandom_range(1, 255)) : $urandom;
      run_mdu((r[0]) ? F_DIVU : F_MULTU, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(push_cnt));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_control_mdu.md
ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 Parameter WIDTH, 32: operand, HI and LO width; legal values are even and at least 8.
REQ-002 Parameter CNT_W, 6: iteration counter width; the value SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 funct  input  6: instruction function field.
REQ-006 ALUOp  input  3: operation class from main control.
REQ-007 valid  input  1: the instruction in decode is real (not a bubble).
REQ-008 op_a  input  WIDTH: rs operand (multiplicand or dividend).
REQ-009 op_b  input  WIDTH: rt operand (multiplier or divisor).
REQ-010 ALUCtrl  output  4: ALU operation select (combinational).
REQ-011 res_sel  output  2: write-back source; 00 = ALU, 01 = HI, 10 = LO.
REQ-012 stall  output  1: pipeline hold while the multiply/divide unit (MDU) is busy.
REQ-013 mdu_done  output  1: one-cycle pulse when HI and LO update.
REQ-014 hi  output  WIDTH: HI register.
REQ-015 lo  output  WIDTH: LO register.

Function
REQ-016 ALUOp decode SHALL be: 010 -> 0010; 011 -> 0110; 000 -> 0000; 001 -> 0001.
REQ-017 ALUOp 100 funct decode SHALL be: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 100111 (nor) -> 1100.
REQ-018 Any unlisted ALUOp/funct combination SHALL drive ALUCtrl = 1111 (no-op); ALUCtrl SHALL never hold a previous value.
REQ-019 res_sel SHALL be 01 for ALUOp 100 with funct 010000 (mfhi), 10 for funct 010010 (mflo), and 00 otherwise.
REQ-020 MDU FSM states: IDLE, MUL, DIV, DONE.
REQ-021 start = valid & ALUOp==100 & state==IDLE & funct==011001 (multu) or 011011 (divu).
REQ-022 On start, the FSM SHALL capture op_a and op_b, clear the counter, and enter MUL or DIV.
REQ-023 MUL SHALL perform unsigned shift-add, one bit per cycle, for exactly WIDTH cycles, then enter DONE.
REQ-024 DIV SHALL perform unsigned restoring division, one quotient bit per cycle, for exactly WIDTH cycles, then enter DONE.
REQ-025 On entering DONE: for multu, {hi,lo} SHALL equal the 2*WIDTH-bit product; for divu, lo SHALL be the quotient and hi the remainder.
REQ-026 DONE SHALL assert mdu_done for one cycle, then return to IDLE.
REQ-027 Latency: start in cycle N; hi/lo are updated and mdu_done is high in cycle N+WIDTH+1.
REQ-028 stall SHALL be high combinationally in the start cycle and in every MUL/DIV cycle.
REQ-029 stall SHALL be low in DONE and in IDLE (except the start cycle).
REQ-030 Divide by zero SHALL take the normal latency and produce lo = all ones and hi = op_a; no exception is raised.
REQ-031 multu/divu while state != IDLE SHALL be ignored; stall prevents this in normal operation.
REQ-032 mfhi/mflo issued while the MDU is busy SHALL assert stall until DONE.
REQ-033 hi/lo SHALL change only in DONE or on reset.
REQ-034 The counter SHALL not wrap; it terminates at WIDTH-1.

Reset
REQ-035 While reset is high: state = IDLE, hi = 0, lo = 0, counter = 0, stall = 0, mdu_done = 0.
REQ-036 Reset during MUL/DIV SHALL abort the operation with no partial update of hi/lo.
REQ-037 ALUCtrl and res_sel SHALL follow their inputs during reset.

Verification
REQ-038 Decode sweep: every ALUOp/funct pair in REQ-016..REQ-019 -> exact ALUCtrl/res_sel; ALUOp 100, funct 000000 -> 1111.
REQ-039 multu, op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, start at cycle N -> stall high N..N+32; at N+33: hi=0xFFFFFFFE, lo=0x00000001, mdu_done=1.
REQ-040 divu, 100/7 -> lo=14, hi=2 at N+33; divu, 5/0 -> lo=0xFFFFFFFF, hi=5 at N+33.
REQ-041 mflo issued at N+5 of a multu -> stall stays high until N+33; res_sel=10 throughout.
REQ-042 reset asserted at N+10 of a divu -> hi=lo=0, state IDLE immediately; a new multu 3*4 after release -> lo=12, hi=0.
REQ-043 Second multu held during busy with valid=1 -> no restart; exactly one mdu_done per accepted start.
